// File: rtl/lidar_frame_parser_pkg.sv
// Shared definitions for the rangefinder distance frame: header, command and
// length bytes, frame size and the parser state encoding.
package lidar_pkg;

  localparam logic [7:0] LIDAR_HDR1        = 8'h55;
  localparam logic [7:0] LIDAR_HDR2        = 8'hAA;
  localparam logic [7:0] LIDAR_CMD_DIST    = 8'h81;
  localparam logic [7:0] LIDAR_LEN_DIST    = 8'h03;
  localparam int         LIDAR_FRAME_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR2,
    CMD,
    LEN,
    DHI,
    DLO,
    STAT,
    CHK
  } lidar_state_e;

  // Modulo-256 accumulation used by the frame checksum.
  function automatic logic [7:0] lidar_sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/lidar_frame_parser_byte_timeout.sv
// Inter-byte gap supervisor: counts idle cycles while enabled and pulses
// expire after LIMIT cycles without a reload. A reload always wins over expiry.
module byte_timeout #(
  parameter int unsigned LIMIT = 21700
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = enable && !reload && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (enable && !reload && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lidar_frame_parser.sv
// Rangefinder distance-frame parser (55 AA 81 03 D_HI D_LO STATUS CRC).
// Define LIDAR_CHECKSUM_CHECK_EN to validate the CRC byte; otherwise it is accepted as-is.
module lidar_frame_parser
  import lidar_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 125_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned TIMEOUT_BYTES = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] dist_mm,
  output logic [7:0]  status,
  output logic        dist_valid,
  output logic        frame_err,
  output logic        crc_err,
  output logic        timeout_err,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);

  lidar_state_e state_q, state_d;
  logic [7:0]   dhi_q, dhi_d;
  logic [7:0]   dlo_q, dlo_d;
  logic [7:0]   stat_q, stat_d;
  logic [15:0]  dist_q, dist_d;
  logic [7:0]   status_q, status_d;
  logic [15:0]  pkt_cnt_q, pkt_cnt_d;
  logic         dist_valid_q, dist_valid_d;
  logic         frame_err_q, frame_err_d;
  logic         timeout_err_q, timeout_err_d;
  logic         frame_ok;
  logic         tmo_expire;

`ifdef LIDAR_CHECKSUM_CHECK_EN
  logic [7:0]   sum_q, sum_d;
  logic         crc_err_q, crc_err_d;
`endif

  byte_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk_in),
    .rst    (rst),
    .enable (state_q != IDLE),
    .reload (rx_valid),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d       = state_q;
    dhi_d         = dhi_q;
    dlo_d         = dlo_q;
    stat_d        = stat_q;
    dist_d        = dist_q;
    status_d      = status_q;
    pkt_cnt_d     = pkt_cnt_q;
    dist_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
`ifdef LIDAR_CHECKSUM_CHECK_EN
    sum_d         = sum_q;
    crc_err_d     = 1'b0;
    frame_ok      = (rx_data == sum_q);
`else
    frame_ok      = 1'b1;
`endif

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == LIDAR_HDR1) state_d = HDR2;
        end
        HDR2: begin
          // A repeated 55 may be the real start of a frame, so stay put.
          if (rx_data == LIDAR_HDR2) begin
            state_d = CMD;
`ifdef LIDAR_CHECKSUM_CHECK_EN
            sum_d   = '0;
`endif
          end else if (rx_data != LIDAR_HDR1) begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (rx_data == LIDAR_CMD_DIST) begin
            state_d = LEN;
`ifdef LIDAR_CHECKSUM_CHECK_EN
            sum_d   = lidar_sum8(sum_q, rx_data);
`endif
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end
        LEN: begin
          if (rx_data == LIDAR_LEN_DIST) begin
            state_d = DHI;
`ifdef LIDAR_CHECKSUM_CHECK_EN
            sum_d   = lidar_sum8(sum_q, rx_data);
`endif
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end
        DHI: begin
          dhi_d   = rx_data;
          state_d = DLO;
`ifdef LIDAR_CHECKSUM_CHECK_EN
          sum_d   = lidar_sum8(sum_q, rx_data);
`endif
        end
        DLO: begin
          dlo_d   = rx_data;
          state_d = STAT;
`ifdef LIDAR_CHECKSUM_CHECK_EN
          sum_d   = lidar_sum8(sum_q, rx_data);
`endif
        end
        STAT: begin
          stat_d  = rx_data;
          state_d = CHK;
`ifdef LIDAR_CHECKSUM_CHECK_EN
          sum_d   = lidar_sum8(sum_q, rx_data);
`endif
        end
        CHK: begin
          state_d = IDLE;
          if (frame_ok) begin
            dist_d       = {dhi_q, dlo_q};
            status_d     = stat_q;
            dist_valid_d = 1'b1;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
          end
`ifdef LIDAR_CHECKSUM_CHECK_EN
          else begin
            crc_err_d = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_expire) begin
      // Stalled partial frame: drop it along with any latched payload.
      state_d       = IDLE;
      timeout_err_d = 1'b1;
      dhi_d         = '0;
      dlo_d         = '0;
      stat_d        = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dhi_q         <= '0;
      dlo_q         <= '0;
      stat_q        <= '0;
      dist_q        <= '0;
      status_q      <= '0;
      pkt_cnt_q     <= '0;
      dist_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dhi_q         <= dhi_d;
      dlo_q         <= dlo_d;
      stat_q        <= stat_d;
      dist_q        <= dist_d;
      status_q      <= status_d;
      pkt_cnt_q     <= pkt_cnt_d;
      dist_valid_q  <= dist_valid_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef LIDAR_CHECKSUM_CHECK_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign dist_mm     = dist_q;
  assign status      = status_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign dist_valid  = dist_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lidar_frame_parser.sv
// Self-checking bench for lidar_frame_parser: directed frames from the test plan
// plus randomized frame-level segments checked against a frame-outcome model.
module tb_lidar_frame_parser;
  import lidar_pkg::*;

  localparam int LIMIT = 2 * 10 * (125_000_000 / 115200);
`ifdef LIDAR_CHECKSUM_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // pulse vector order: {dist_valid, frame_err, crc_err, timeout_err}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_GOOD = 4'b1000;
  localparam logic [3:0] P_FRM  = 4'b0100;
  localparam logic [3:0] P_CRC  = 4'b0010;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] dist_mm;
  logic [7:0]  status;
  logic        dist_valid, frame_err, crc_err, timeout_err;
  logic [15:0] pkt_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_dist = 16'h0;
  logic [7:0]  m_stat = 8'h0;
  logic [15:0] m_cnt  = 16'h0;

  lidar_frame_parser dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dist_mm     (dist_mm),
    .status      (status),
    .dist_valid  (dist_valid),
    .frame_err   (frame_err),
    .crc_err     (crc_err),
    .timeout_err (timeout_err),
    .pkt_cnt     (pkt_cnt)
  );

  always #4 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outs(input logic [3:0] pulses);
    chk("pulses", 32'({dist_valid, frame_err, crc_err, timeout_err}), 32'(pulses));
    chk("dist_mm", 32'(dist_mm), 32'(m_dist));
    chk("status", 32'(status), 32'(m_stat));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] exp_p);
    @(negedge clk_in);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_in);
    #1;
    rx_valid = 1'b0;
    check_outs(exp_p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      rx_valid = 1'b0;
      @(posedge clk_in);
      #1;
      check_outs(P_NONE);
    end
  endtask

  function automatic logic [7:0] frame_sum(input logic [15:0] d, input logic [7:0] s);
    logic [7:0] r;
    r = LIDAR_CMD_DIST + LIDAR_LEN_DIST + d[15:8] + d[7:0] + s;
    return r;
  endfunction

  task automatic send_frame(input logic [15:0] d, input logic [7:0] s, input logic [7:0] crc);
    logic good;
    good = !CK || (crc == frame_sum(d, s));
    send_byte(LIDAR_HDR1, P_NONE);
    send_byte(LIDAR_HDR2, P_NONE);
    send_byte(LIDAR_CMD_DIST, P_NONE);
    send_byte(LIDAR_LEN_DIST, P_NONE);
    send_byte(d[15:8], P_NONE);
    send_byte(d[7:0], P_NONE);
    send_byte(s, P_NONE);
    if (good) begin
      m_dist = d;
      m_stat = s;
      m_cnt  = m_cnt + 16'd1;
      send_byte(crc, P_GOOD);
    end else begin
      send_byte(crc, P_CRC);
    end
  endtask

  task automatic send_good(input logic [15:0] d, input logic [7:0] s);
    send_frame(d, s, frame_sum(d, s));
  endtask

  function automatic logic [7:0] rand_not(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    do r = 8'($urandom_range(0, 255)); while (r == a || r == b);
    return r;
  endfunction

  task automatic random_segment();
    logic [15:0] d;
    logic [7:0]  s;
    d = 16'($urandom_range(0, 65535));
    s = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 6))
      0: send_good(d, s);
      1: send_frame(d, s, frame_sum(d, s) ^ rand_not(8'h00, 8'h00));
      2: begin
        send_byte(LIDAR_HDR1, P_NONE);
        send_byte(LIDAR_HDR2, P_NONE);
        send_byte(rand_not(LIDAR_CMD_DIST, LIDAR_CMD_DIST), P_FRM);
      end
      3: begin
        send_byte(LIDAR_HDR1, P_NONE);
        send_byte(LIDAR_HDR2, P_NONE);
        send_byte(LIDAR_CMD_DIST, P_NONE);
        send_byte(rand_not(LIDAR_LEN_DIST, LIDAR_LEN_DIST), P_FRM);
      end
      4: begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          send_byte(rand_not(LIDAR_HDR1, LIDAR_HDR1), P_NONE);
      end
      5: begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          send_byte(LIDAR_HDR1, P_NONE);
        send_good(d, s);
      end
      default: begin
        send_byte(LIDAR_HDR1, P_NONE);
        send_byte(rand_not(LIDAR_HDR1, LIDAR_HDR2), P_NONE);
      end
    endcase
  endtask

  initial begin
    int tmo_cnt;
    int tmo_at;

    // reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_outs(P_NONE);
    @(negedge clk_in);
    rst = 1'b0;
    idle(2);

    // three good frames
    send_good(16'd100, 8'h00);
    send_good(16'd180, 8'h00);
    send_good(16'd380, 8'h00);
    chk("three_frames_cnt", 32'(pkt_cnt), 32'd3);
    chk("last_dist", 32'(dist_mm), 32'h017C);

    // 100 mm frame with a wrong CRC byte
    send_frame(16'd100, 8'h00, 8'hFA);

    // resync on a repeated header
    send_byte(LIDAR_HDR1, P_NONE);
    send_frame(16'h012C, 8'h00, 8'hB1);

    // wrong command byte, then a good 200 mm frame
    send_byte(LIDAR_HDR1, P_NONE);
    send_byte(LIDAR_HDR2, P_NONE);
    send_byte(8'h82, P_FRM);
    send_frame(16'd200, 8'h80, 8'hCC);

    // stall after the command byte
    send_byte(LIDAR_HDR1, P_NONE);
    send_byte(LIDAR_HDR2, P_NONE);
    send_byte(LIDAR_CMD_DIST, P_NONE);
    tmo_cnt = 0;
    tmo_at  = 0;
    for (int i = 1; i <= LIMIT + 50; i++) begin
      @(posedge clk_in);
      #1;
      if (timeout_err) begin
        tmo_cnt++;
        if (tmo_at == 0) tmo_at = i;
      end
    end
    chk("tmo_count", 32'(tmo_cnt), 32'd1);
    chk("tmo_window", 32'(tmo_at >= LIMIT && tmo_at <= LIMIT + 1), 32'd1);
    check_outs(P_NONE);
    send_good(16'h1234, 8'h5A);

    // gap just under the limit must not abort the frame
    send_byte(LIDAR_HDR1, P_NONE);
    send_byte(LIDAR_HDR2, P_NONE);
    tmo_cnt = 0;
    for (int i = 0; i < LIMIT - 100; i++) begin
      @(posedge clk_in);
      #1;
      if (timeout_err) tmo_cnt++;
    end
    chk("no_tmo_count", 32'(tmo_cnt), 32'd0);
    begin
      logic [15:0] d;
      logic [7:0]  s;
      d = 16'h0BEE;
      s = 8'h11;
      send_byte(LIDAR_CMD_DIST, P_NONE);
      send_byte(LIDAR_LEN_DIST, P_NONE);
      send_byte(d[15:8], P_NONE);
      send_byte(d[7:0], P_NONE);
      send_byte(s, P_NONE);
      m_dist = d;
      m_stat = s;
      m_cnt  = m_cnt + 16'd1;
      send_byte(frame_sum(d, s), P_GOOD);
    end

    // reset mid-frame after D_HI
    send_byte(LIDAR_HDR1, P_NONE);
    send_byte(LIDAR_HDR2, P_NONE);
    send_byte(LIDAR_CMD_DIST, P_NONE);
    send_byte(LIDAR_LEN_DIST, P_NONE);
    send_byte(8'h02, P_NONE);
    @(negedge clk_in);
    rst    = 1'b1;
    m_dist = '0;
    m_stat = '0;
    m_cnt  = '0;
    #1;
    check_outs(P_NONE);
    send_byte(8'h10, P_NONE);
    send_byte(8'h00, P_NONE);
    send_byte(8'h95, P_NONE);
    @(negedge clk_in);
    rst = 1'b0;
    idle(1);
    send_byte(8'h10, P_NONE);
    send_good(16'd250, 8'h03);
    chk("post_reset_cnt", 32'(pkt_cnt), 32'd1);

    // randomized frame-level segments with random gaps
    for (int n = 0; n < 250; n++) begin
      random_segment();
      idle(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
